// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: PC type, sequencer states and default vectors.
package cpu_pkg;

    typedef logic [31:0] pc_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam pc_t PC_INC        = 32'd4;
    localparam pc_t DEF_RESET_VEC = 32'h0000_0000;
    localparam pc_t DEF_EXC_VEC   = 32'h0000_0380;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: exception > redirect > pending redirect > sequential PC+4.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter pc_t EXC_VEC = DEF_EXC_VEC
) (
    input  logic i_exc,
    input  logic i_redir,
    input  pc_t  i_redir_target,
    input  logic i_pend,
    input  pc_t  i_pend_target,
    input  pc_t  i_pc,
    output pc_t  o_pc_next
);

    always_comb begin
        if (i_exc)
            o_pc_next = EXC_VEC;
        else if (i_redir)
            o_pc_next = i_redir_target;
        else if (i_pend)
            o_pc_next = i_pend_target;
        else
            o_pc_next = i_pc + PC_INC;  // wraps modulo 2^32
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetches over imem req/ack and hands instructions to decode.
// Build option: define PC_ALIGN_CHECK_EN to trap misaligned redirects and add the misalign output.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter pc_t RESET_VEC = DEF_RESET_VEC,
    parameter pc_t EXC_VEC   = DEF_EXC_VEC,
    parameter int  MAX_WAIT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output pc_t         imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output pc_t         inst_pc,
    input  logic        inst_ready,
    input  logic        stall,
    input  logic        redirect_valid,
    input  pc_t         redirect_target,
    input  logic        exc_valid,
    output logic        timeout,
    output pc_t         pc
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    localparam int CW = $clog2(MAX_WAIT);

    state_t         r_state;
    pc_t            r_pc;
    logic [31:0]    r_inst;
    pc_t            r_inst_pc;
    logic           r_inst_valid;
    logic [CW-1:0]  r_wait_cnt;
    logic           r_redir_pend;
    logic           r_pend_exc;
    pc_t            r_pend_target;

    state_t         w_state_nxt;
    pc_t            w_pc_nxt;
    pc_t            w_sel_pc;
    logic           w_inst_valid_nxt;
    logic           w_load_inst;
    logic [CW-1:0]  w_wait_nxt;
    logic           w_pend_nxt;
    logic           w_pend_exc_nxt;
    pc_t            w_pend_tgt_nxt;
    logic           w_timeout;
    logic           w_exc;
    logic           w_redir;
    pc_t            w_redir_tgt;
    logic           w_accept;

`ifdef PC_ALIGN_CHECK_EN
    logic w_misalign_ev;
    logic r_misalign;

    // A misaligned redirect is promoted to an exception instead of being followed.
    assign w_misalign_ev = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign w_exc         = exc_valid || w_misalign_ev;
    assign w_redir       = redirect_valid && !w_misalign_ev;
    assign w_redir_tgt   = redirect_target;
    assign misalign      = r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_misalign <= 1'b0;
        else
            r_misalign <= w_misalign_ev && (r_state != BOOT);
    end
`else
    assign w_exc       = exc_valid;
    assign w_redir     = redirect_valid;
    assign w_redir_tgt = redirect_target & ~32'd3;
`endif

    assign w_accept = r_inst_valid && inst_ready && !stall;

    pc_next_sel #(
        .EXC_VEC        (EXC_VEC)
    ) u_next_sel (
        .i_exc          (w_exc),
        .i_redir        (w_redir),
        .i_redir_target (w_redir_tgt),
        .i_pend         (r_redir_pend),
        .i_pend_target  (r_pend_target),
        .i_pc           (r_pc),
        .o_pc_next      (w_sel_pc)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_valid_nxt = r_inst_valid;
        w_load_inst      = 1'b0;
        w_wait_nxt       = r_wait_cnt;
        w_pend_nxt       = r_redir_pend;
        w_pend_exc_nxt   = r_pend_exc;
        w_pend_tgt_nxt   = r_pend_target;
        w_timeout        = 1'b0;

        case (r_state)
            BOOT: begin
                if (exc_valid)
                    w_pc_nxt = EXC_VEC;
                else
                    w_state_nxt = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    w_wait_nxt = '0;
                    if (w_exc || w_redir || r_redir_pend) begin
                        // Returned word is wrong-path; refetch from the chosen target.
                        w_pc_nxt       = w_sel_pc;
                        w_pend_nxt     = 1'b0;
                        w_pend_exc_nxt = 1'b0;
                    end else begin
                        w_load_inst      = 1'b1;
                        w_inst_valid_nxt = 1'b1;
                        w_state_nxt      = OUT;
                    end
                end else if (r_wait_cnt == CW'(MAX_WAIT - 1)) begin
                    w_timeout      = 1'b1;
                    w_pc_nxt       = EXC_VEC;
                    w_pend_nxt     = 1'b0;
                    w_pend_exc_nxt = 1'b0;
                    w_wait_nxt     = '0;
                    w_state_nxt    = BOOT;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                    // A pending exception is not displaced by a later plain redirect.
                    if (w_exc || (w_redir && !(r_redir_pend && r_pend_exc))) begin
                        w_pend_nxt     = 1'b1;
                        w_pend_exc_nxt = w_exc;
                        w_pend_tgt_nxt = w_sel_pc;
                    end
                end
            end
            OUT: begin
                if (w_exc || w_redir || w_accept) begin
                    w_pc_nxt         = w_sel_pc;
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = REQ;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VEC;
            r_inst        <= '0;
            r_inst_pc     <= '0;
            r_inst_valid  <= 1'b0;
            r_wait_cnt    <= '0;
            r_redir_pend  <= 1'b0;
            r_pend_exc    <= 1'b0;
            r_pend_target <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_inst_valid  <= w_inst_valid_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_redir_pend  <= w_pend_nxt;
            r_pend_exc    <= w_pend_exc_nxt;
            r_pend_target <= w_pend_tgt_nxt;
            if (w_load_inst) begin
                r_inst    <= imem_rdata;
                r_inst_pc <= r_pc;
            end
        end
    end

    assign imem_req   = (r_state == REQ);
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;
    assign timeout    = w_timeout;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch flow, stall, redirects, timeout, wrap and reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_valid;
    logic        timeout;
    logic [31:0] pc;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_VEC       (32'h0000_0000),
        .EXC_VEC         (32'h0000_0380),
        .MAX_WAIT        (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .timeout         (timeout),
        .pc              (pc)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign        (misalign)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at the first REQ cycle for address a; acks on the second cycle; returns in OUT.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
        check("req_on", imem_req, 32'd1);
        check("addr_req1", imem_addr, a);
        @(negedge clk);
        check("addr_req2", imem_addr, a);
        imem_ack   = 1'b1;
        imem_rdata = d;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("inst_valid", inst_valid, 32'd1);
        check("inst", inst, d);
        check("inst_pc", inst_pc, a);
    endtask

    initial begin
        logic [31:0] a_exp;

        rst             = 1'b1;
        imem_ack        = 1'b0;
        imem_rdata      = '0;
        inst_ready      = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        exc_valid       = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_pc", pc, 32'h0);
        check("rst_req", imem_req, 32'd0);
        check("rst_valid", inst_valid, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_timeout", timeout, 32'd0);

        rst        = 1'b0;
        inst_ready = 1'b1;
        check("boot_req", imem_req, 32'd0);
        @(negedge clk);

        // Sequential fetch 0x0, 0x4, 0x8
        do_fetch(32'h0, 32'h1111_0000);
        @(negedge clk);
        check("valid_drop", inst_valid, 32'd0);
        do_fetch(32'h4, 32'h1111_0004);
        @(negedge clk);
        do_fetch(32'h8, 32'h1111_0008);

        // Stall holds the instruction for three cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", inst_valid, 32'd1);
            check("stall_inst", inst, 32'h1111_0008);
            check("stall_inst_pc", inst_pc, 32'h8);
            check("stall_pc", pc, 32'h8);
            @(negedge clk);
        end
        stall = 1'b0;
        check("stall_release_valid", inst_valid, 32'd1);
        @(negedge clk);
        check("after_stall_addr", imem_addr, 32'hC);
        do_fetch(32'hC, 32'h1111_000C);
        @(negedge clk);

        // Redirect while a request to 0x10 is outstanding
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        check("pend_addr0", imem_addr, 32'h10);
        @(negedge clk);
        redirect_valid  = 1'b0;
        redirect_target = '0;
        check("pend_addr1", imem_addr, 32'h10);
        check("pend_req", imem_req, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("discard_valid", inst_valid, 32'd0);
        check("discard_addr", imem_addr, 32'h40);
        do_fetch(32'h40, 32'h2222_0040);

        // Redirect and exception together in OUT, with decode ready: exception wins
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        exc_valid       = 1'b1;
        @(negedge clk);
        redirect_valid  = 1'b0;
        redirect_target = '0;
        exc_valid       = 1'b0;
        check("squash_valid", inst_valid, 32'd0);
        check("squash_addr", imem_addr, 32'h380);
        check("squash_req", imem_req, 32'd1);

        // No ack: timeout fires in the 16th REQ cycle
        for (int k = 1; k < 16; k++) begin
            check("to_low", timeout, 32'd0);
            check("to_addr", imem_addr, 32'h380);
            @(negedge clk);
        end
        check("to_pulse", timeout, 32'd1);
        check("to_req", imem_req, 32'd1);
        @(negedge clk);
        check("to_boot_req", imem_req, 32'd0);
        check("to_boot_pulse", timeout, 32'd0);
        check("to_boot_pc", pc, 32'h380);
        @(negedge clk);
        check("to_refetch_req", imem_req, 32'd1);
        check("to_refetch_addr", imem_addr, 32'h380);

        // Pending exception is not overwritten by a later plain redirect
        exc_valid = 1'b1;
        @(negedge clk);
        exc_valid       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        @(negedge clk);
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_ack        = 1'b1;
        imem_rdata      = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("pend_exc_valid", inst_valid, 32'd0);
        check("pend_exc_addr", imem_addr, 32'h380);
        do_fetch(32'h380, 32'h3333_0380);

        // Misaligned redirect target 0x42
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        @(negedge clk);
        redirect_valid  = 1'b0;
        redirect_target = '0;
`ifdef PC_ALIGN_CHECK_EN
        a_exp = 32'h380;
        check("misalign_pulse", misalign, 32'd1);
        check("misalign_addr", imem_addr, a_exp);
        @(negedge clk);
        check("misalign_clear", misalign, 32'd0);
`else
        a_exp = 32'h40;
        check("align_force_addr", imem_addr, a_exp);
`endif
        do_fetch(a_exp, 32'h4444_0000);

        // PC+4 wraps at the top of the address space
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid  = 1'b0;
        redirect_target = '0;
        do_fetch(32'hFFFF_FFFC, 32'h5555_FFFC);
        @(negedge clk);
        check("wrap_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 32'h6666_0000);
        @(negedge clk);
        check("pre_rst_addr", imem_addr, 32'h4);

        // Reset in the middle of a handshake
        imem_ack   = 1'b1;
        imem_rdata = 32'h7777_7777;
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", imem_req, 32'd0);
        check("arst_pc", pc, 32'h0);
        check("arst_valid", inst_valid, 32'd0);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        rst        = 1'b0;
        check("arst_boot_req", imem_req, 32'd0);
        check("arst_inst", inst, 32'h0);
        @(negedge clk);
        check("arst_refetch_req", imem_req, 32'd1);
        check("arst_refetch_addr", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch from instruction memory through a req/ack handshake.
- Presents each fetched instruction to decode through a valid/ready handshake.
- Applies next-PC selection with fixed priority: exception, then redirect (branch/jump), then sequential PC+4.
- Replaces the bare PC register in the multi-cycle / stall-capable CPU datapath.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset
EXC_VEC, 32'h0000_0380, exception / fetch-timeout vector
MAX_WAIT, 16, cycles REQ may wait for imem_ack before timeout (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch address, equals pc, stable while imem_req=1
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
inst_valid  out  1  inst/inst_pc valid for decode
inst  out  32  registered instruction
inst_pc  out  32  address of inst
inst_ready  in  1  decode accepts inst this cycle
stall  in  1  hazard stall; blocks acceptance in OUT
redirect_valid  in  1  branch/jump taken
redirect_target  in  32  redirect address
exc_valid  in  1  exception request; highest priority
timeout  out  1  one-cycle pulse on fetch timeout
pc  out  32  current PC

Behaviour:
- Reset (rst async, active-high; clock clk): pc=RESET_VEC, state=BOOT, imem_req=0, inst_valid=0, inst=0, inst_pc=0, timeout=0, wait_cnt=0, redir_pend=0.
- BOOT:
  - imem_req=0 for one cycle, then go to REQ.
  - exc_valid in BOOT: pc<=EXC_VEC, stay one more BOOT cycle.
- REQ:
  - imem_req=1, imem_addr=pc; wait_cnt increments each cycle without ack.
  - On imem_ack with redir_pend=0: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go to OUT. Fetch-to-valid latency is 1 cycle after ack.
  - On imem_ack with redir_pend=1: discard data, pc<=pend_target, clear redir_pend, stay in REQ; a new request starts the next cycle.
  - exc_valid/redirect_valid while in REQ: the outstanding request cannot be aborted. Record redir_pend=1 and pend_target (EXC_VEC if exc_valid, else redirect_target). A later higher-or-equal priority event overwrites pend_target.
  - wait_cnt reaches MAX_WAIT-1 without ack: timeout=1 for one cycle, pc<=EXC_VEC, redir_pend<=0, go to BOOT. wait_cnt clears on leaving REQ.
- OUT:
  - Hold inst_valid=1 with inst/inst_pc stable until accepted.
  - Acceptance = inst_valid && inst_ready && !stall. On acceptance: pc<=pc+4 (wraps modulo 2^32), inst_valid<=0, go to REQ.
  - exc_valid or redirect_valid in OUT: squash. inst_valid<=0 next cycle, pc<=EXC_VEC or redirect_target, go to REQ. This applies even if acceptance occurs the same cycle; the redirect wins.
  - Both exc_valid and redirect_valid asserted: EXC_VEC is used.
- pc updates only at state transitions listed above; otherwise it holds.
- Reset mid-handshake: imem_req drops asynchronously; pending data is ignored.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - redirect_target[1:0]!=0 is treated as an exception: pc<=EXC_VEC.
  - Extra output port misalign pulses 1 cycle.
- Undefined:
  - redirect_target[1:0] is forced to 2'b00.
  - No misalign port exists.

Decomposition:
- Shared package cpu_pkg: state enum {BOOT, REQ, OUT}, PC_INC=32'd4, default RESET_VEC/EXC_VEC constants, pc_t (32-bit) typedef.
- One natural sub-module, pc_next_sel: combinational priority mux (exc > redirect > pending > sequential) that produces the next pc. The FSM, counter and output registers stay in pc_sequencer.

Test Plan:
- Reset then memory acks 1 cycle after each req, inst_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; inst_valid pulses with inst_pc matching; first req 1 cycle after rst release.
- OUT with inst_pc=0x8, stall=1 for 3 cycles then 0 -> inst held stable 3 cycles; next imem_addr=0xC.
- In WAIT (req pending at 0x10), redirect_target=0x40 -> ack data discarded, no inst_valid; next imem_addr=0x40.
- In OUT, redirect_valid (0x100) and exc_valid in the same cycle -> inst_valid drops; next imem_addr=0x380.
- imem_ack never asserted, MAX_WAIT=16 -> timeout pulse in 16th REQ cycle; BOOT 1 cycle; imem_addr=0x380.
- With PC_ALIGN_CHECK_EN, redirect_target=0x42 -> misalign pulse, imem_addr=0x380; without the macro -> imem_addr=0x40.
